// File: rtl/rvvLitePkg.sv
// Shared types for the vector-configuration issue path: FSM state encoding,
// the decoded VSET* instruction, and the vl zero-extension helper.
package rvvLitePkg;

    typedef enum logic [1:0] {
        VCFG_IDLE   = 2'd0,
        VCFG_ISSUE  = 2'd1,
        VCFG_SETTLE = 2'd2,
        VCFG_RESP   = 2'd3
    } vcfg_issue_state_e;

    typedef enum logic [1:0] {
        VCFG_OP_VSETVLI  = 2'd0,
        VCFG_OP_VSETIVLI = 2'd1,
        VCFG_OP_VSETVL   = 2'd2
    } vcfg_op_e;

    typedef struct packed {
        vcfg_op_e    op;
        logic [4:0]  rd_addr;
        logic [4:0]  rs1_addr;   // doubles as uimm for VSETIVLI
        logic [10:0] vtypei;
    } vcfg_instruction_t;

    localparam int VCFG_MAX_W = 64;

    // Keep only the low vl_bits of vl; everything above is forced to zero.
    function automatic logic [VCFG_MAX_W-1:0] VCFG_RESP_ZEXT(
        input logic [VCFG_MAX_W-1:0] vl,
        input int                    vl_bits
    );
        logic [VCFG_MAX_W-1:0] mask;
        mask = '0;
        for (int i = 0; i < VCFG_MAX_W; i++) begin
            if (i < vl_bits) mask[i] = 1'b1;
        end
        return vl & mask;
    endfunction

endpackage

// File: rtl/vcfg_issue.sv
// Initiator side of the VSET* configuration handshake: takes one request from
// the core, holds cfg_valid until the configuration unit acks, captures vl and
// returns it as the rd writeback response. One request in flight.
// Optional feature macro: VCFG_ISSUE_TIMEOUT_EN (abort ISSUE after
// TIMEOUT_CYCLES without ack, respond with resp_err=1).
module vcfg_issue
    import rvvLitePkg::*;
#(
    parameter int XLEN           = 32,
    parameter int VL_BITS        = 8,
    parameter int ID_W           = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  vcfg_instruction_t        req_insn,
    input  logic [XLEN-1:0]          req_rs1,
    input  logic [XLEN-1:0]          req_rs2,
    input  logic [ID_W-1:0]          req_id,
    output logic                     cfg_valid,
    output vcfg_instruction_t        cfg_insn,
    output logic [1:2][XLEN-1:0]     cfg_rf,
    input  logic                     cfg_ack,
    input  logic [VL_BITS-1:0]       cfg_vl,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [XLEN-1:0]          resp_data,
    output logic [ID_W-1:0]          resp_id,
    output logic [4:0]               resp_rd,
    output logic                     resp_err
);

    // Reject configurations the datapath cannot represent.
    if (TIMEOUT_CYCLES < 1 || VL_BITS > XLEN || XLEN > VCFG_MAX_W) begin : g_param_check
        $error("vcfg_issue: unsupported parameter combination");
    end

    vcfg_issue_state_e state_q, state_d;
    logic              accept;
    logic              timeout_hit;

`ifdef VCFG_ISSUE_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt;

    // Dwell counter: cleared when a request is accepted (i.e. on ISSUE entry),
    // counts every ISSUE cycle; ISSUE is left once it hits TIMEOUT_CYCLES.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                         to_cnt <= '0;
        else if (accept)                 to_cnt <= '0;
        else if (state_q == VCFG_ISSUE)  to_cnt <= to_cnt + TO_W'(1);
    end
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= VCFG_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; an ack outside ISSUE has no effect.
    always_comb begin
        state_d = state_q;
        case (state_q)
            VCFG_IDLE:   if (req_valid) state_d = VCFG_ISSUE;
            VCFG_ISSUE:  if (cfg_ack)          state_d = VCFG_SETTLE;
                         else if (timeout_hit) state_d = VCFG_RESP;
            VCFG_SETTLE: state_d = VCFG_RESP;
            VCFG_RESP:   if (resp_ready) state_d = VCFG_IDLE;
            default:     state_d = VCFG_IDLE;
        endcase
    end

    // Decoded controls: req_ready straight from state, no skid buffer.
    always_comb begin
        req_ready   = (state_q == VCFG_IDLE);
        accept      = req_ready & req_valid;
`ifdef VCFG_ISSUE_TIMEOUT_EN
        timeout_hit = (state_q == VCFG_ISSUE) && (to_cnt == TO_W'(TIMEOUT_CYCLES));
`else
        timeout_hit = 1'b0;
`endif
    end

    // Registered outputs. cfg_valid/resp_valid follow the next state so both
    // are clean flops; passing through SETTLE and RESP leaves cfg_valid low for
    // at least two cycles before the next request can raise it again.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_valid  <= 1'b0;
            cfg_insn   <= '0;
            cfg_rf     <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_id    <= '0;
            resp_rd    <= '0;
        end else begin
            cfg_valid  <= (state_d == VCFG_ISSUE);
            resp_valid <= (state_d == VCFG_RESP);
            if (accept) begin
                cfg_insn  <= req_insn;
                cfg_rf[1] <= req_rs1;
                cfg_rf[2] <= req_rs2;
                resp_id   <= req_id;
                resp_rd   <= req_insn.rd_addr;
            end
            if (state_q == VCFG_SETTLE)
                resp_data <= XLEN'(VCFG_RESP_ZEXT(VCFG_MAX_W'(cfg_vl), VL_BITS));
            else if (timeout_hit && !cfg_ack)
                resp_data <= '0;
        end
    end

`ifdef VCFG_ISSUE_TIMEOUT_EN
    // Error flag: cleared per request, set when ISSUE is abandoned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                          resp_err <= 1'b0;
        else if (accept)                  resp_err <= 1'b0;
        else if (timeout_hit && !cfg_ack) resp_err <= 1'b1;
    end
`else
    assign resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_vcfg_issue.sv
// Directed bench for vcfg_issue: cycle-accurate handshake checks with
// hand-computed expectations. Timeout scenario is built only when
// VCFG_ISSUE_TIMEOUT_EN is defined.
module tb_vcfg_issue;
    import rvvLitePkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    vcfg_instruction_t req_insn;
    logic [31:0]       req_rs1, req_rs2;
    logic [3:0]        req_id;
    logic              cfg_valid;
    vcfg_instruction_t cfg_insn;
    logic [1:2][31:0]  cfg_rf;
    logic              cfg_ack;
    logic [7:0]        cfg_vl;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_data;
    logic [3:0]        resp_id;
    logic [4:0]        resp_rd;
    logic              resp_err;

    int errors = 0;
    int checks = 0;

    vcfg_issue #(.XLEN(32), .VL_BITS(8), .ID_W(4), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_insn(req_insn),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_id(req_id),
        .cfg_valid(cfg_valid), .cfg_insn(cfg_insn), .cfg_rf(cfg_rf),
        .cfg_ack(cfg_ack), .cfg_vl(cfg_vl),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_id(resp_id), .resp_rd(resp_rd), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; everything is driven and sampled 1 ns after posedge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"},  64'(req_ready), 64'd1);
        chk({tag, "_cfg_valid"},  64'(cfg_valid), 64'd0);
        chk({tag, "_cfg_insn"},   64'(cfg_insn), 64'd0);
        chk({tag, "_cfg_rf"},     64'(cfg_rf), 64'd0);
        chk({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
        chk({tag, "_resp_data"},  64'(resp_data), 64'd0);
        chk({tag, "_resp_id"},    64'(resp_id), 64'd0);
        chk({tag, "_resp_rd"},    64'(resp_rd), 64'd0);
        chk({tag, "_resp_err"},   64'(resp_err), 64'd0);
    endtask

    // One full transaction starting in an IDLE cycle (cycle 0 = accept).
    // n_ack: cycle of the ack; hold: cycles resp_ready stays low in RESP;
    // pend: keep req_valid high while held to prove no early acceptance.
    task automatic do_req(input vcfg_instruction_t insn, input logic [31:0] rs1,
                          input logic [31:0] rs2, input logic [3:0] id,
                          input int n_ack, input logic [7:0] vl,
                          input int hold, input bit pend);
        logic [31:0] exp_data;
        exp_data = {24'd0, vl};
        chk("c0_req_ready", 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_insn = insn; req_rs1 = rs1; req_rs2 = rs2; req_id = id;
        step();
        req_valid = 1'b0; req_insn = '0; req_rs1 = '1; req_rs2 = '1; req_id = '0;
        for (int c = 1; c <= n_ack; c++) begin
            chk("issue_cfg_valid", 64'(cfg_valid), 64'd1);
            chk("issue_cfg_insn", 64'(cfg_insn), 64'(insn));
            chk("issue_rs1", 64'(cfg_rf[1]), 64'(rs1));
            chk("issue_rs2", 64'(cfg_rf[2]), 64'(rs2));
            chk("issue_req_ready", 64'(req_ready), 64'd0);
            chk("issue_resp_valid", 64'(resp_valid), 64'd0);
            if (c == n_ack) cfg_ack = 1'b1;
            step();
            cfg_ack = 1'b0;
        end
        // SETTLE: config unit has just updated vl
        cfg_vl = vl;
        chk("settle_cfg_valid", 64'(cfg_valid), 64'd0);
        chk("settle_resp_valid", 64'(resp_valid), 64'd0);
        step();
        // RESP
        chk("resp_valid", 64'(resp_valid), 64'd1);
        chk("resp_data", 64'(resp_data), 64'(exp_data));
        chk("resp_id", 64'(resp_id), 64'(id));
        chk("resp_rd", 64'(resp_rd), 64'(insn.rd_addr));
        chk("resp_err", 64'(resp_err), 64'd0);
        chk("resp_cfg_valid", 64'(cfg_valid), 64'd0);
        for (int h = 0; h < hold; h++) begin
            resp_ready = 1'b0;
            if (pend) begin
                req_valid = 1'b1; req_id = id + 4'd1;
            end
            cfg_ack = (h == 1);   // stray ack, must be ignored
            step();
            cfg_ack = 1'b0;
            chk("hold_resp_valid", 64'(resp_valid), 64'd1);
            chk("hold_resp_data", 64'(resp_data), 64'(exp_data));
            chk("hold_resp_id", 64'(resp_id), 64'(id));
            chk("hold_resp_rd", 64'(resp_rd), 64'(insn.rd_addr));
            chk("hold_req_ready", 64'(req_ready), 64'd0);
            chk("hold_cfg_valid", 64'(cfg_valid), 64'd0);
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        // IDLE again, still no cfg_valid
        chk("post_resp_valid", 64'(resp_valid), 64'd0);
        chk("post_req_ready", 64'(req_ready), 64'd1);
        chk("post_cfg_valid", 64'(cfg_valid), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vcfg_instruction_t i_vli, i_ivli, i_vl;
        i_vli  = '{op: VCFG_OP_VSETVLI,  rd_addr: 5'd10, rs1_addr: 5'd11, vtypei: 11'h0d3};
        i_ivli = '{op: VCFG_OP_VSETIVLI, rd_addr: 5'd12, rs1_addr: 5'd9,  vtypei: 11'h010};
        i_vl   = '{op: VCFG_OP_VSETVL,   rd_addr: 5'd0,  rs1_addr: 5'd5,  vtypei: 11'h000};

        rst = 1'b1; req_valid = 1'b0; req_insn = '0; req_rs1 = '0; req_rs2 = '0;
        req_id = '0; cfg_ack = 1'b0; cfg_vl = '0; resp_ready = 1'b0;
        #2;
        chk_reset_outputs("rst");
        step(); step();
        rst = 1'b0;
        step();

        // stray ack while IDLE is ignored
        cfg_ack = 1'b1;
        step();
        cfg_ack = 1'b0;
        chk("idle_ack_req_ready", 64'(req_ready), 64'd1);
        chk("idle_ack_cfg_valid", 64'(cfg_valid), 64'd0);

        // nominal: ack in cycle 2, vl=64, response in cycle 4
        do_req(i_vli, 32'd37, 32'd0, 4'd3, 2, 8'd64, 0, 1'b0);
        // ack delayed to cycle 7, response in cycle 9
        do_req(i_vli, 32'd100, 32'h5a5a_0001, 4'd7, 7, 8'd17, 0, 1'b0);
        // resp_ready held low 5 cycles with a second request pending
        do_req(i_vl, 32'hffff_ffff, 32'h0000_00c1, 4'd9, 3, 8'd255, 5, 1'b1);
        // back-to-back VSETIVLI, ids in order
        do_req(i_ivli, 32'd0, 32'd0, 4'd5, 2, 8'd9, 0, 1'b0);
        do_req(i_ivli, 32'd0, 32'd0, 4'd6, 2, 8'd0, 0, 1'b0);

        // reset pulsed while in ISSUE
        req_valid = 1'b1; req_insn = i_vli; req_rs1 = 32'd1; req_rs2 = 32'd2; req_id = 4'd11;
        step();
        req_valid = 1'b0;
        chk("pre_rst_cfg_valid", 64'(cfg_valid), 64'd1);
        rst = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        #2;
        rst = 1'b0;
        step();
        chk("after_rst_req_ready", 64'(req_ready), 64'd1);
        chk("after_rst_cfg_valid", 64'(cfg_valid), 64'd0);
        do_req(i_ivli, 32'd4, 32'd8, 4'd12, 2, 8'd4, 1, 1'b0);

`ifdef VCFG_ISSUE_TIMEOUT_EN
        // no ack: cfg_valid through cycle 17, error response in cycle 18
        req_valid = 1'b1; req_insn = i_vli; req_rs1 = 32'd3; req_rs2 = 32'd0; req_id = 4'd14;
        step();
        req_valid = 1'b0;
        for (int c = 1; c <= 17; c++) begin
            chk("to_cfg_valid", 64'(cfg_valid), 64'd1);
            chk("to_resp_valid", 64'(resp_valid), 64'd0);
            step();
        end
        chk("to_resp_valid18", 64'(resp_valid), 64'd1);
        chk("to_resp_err", 64'(resp_err), 64'd1);
        chk("to_resp_data", 64'(resp_data), 64'd0);
        chk("to_resp_id", 64'(resp_id), 64'd14);
        chk("to_cfg_valid18", 64'(cfg_valid), 64'd0);
        cfg_ack = 1'b1;
        step();
        cfg_ack = 1'b0;
        chk("to_stray_resp_valid", 64'(resp_valid), 64'd1);
        chk("to_stray_err", 64'(resp_err), 64'd1);
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        chk("to_done_req_ready", 64'(req_ready), 64'd1);
        do_req(i_vli, 32'd5, 32'd0, 4'd15, 2, 8'd32, 0, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
